serial_paralelo_rx: RTL and testbench

Serial-to-parallel receiver for the ParaleloSerial lane: consumes the MSB-first bit stream produced on the serial side and rebuilds bytes on the single fast bit clock. It searches for comma symbols (K28.5 byte 0xBC) to find byte alignment, declares the lane active after a run of consecutive commas, then presents each data byte with a one-cycle valid strobe. It uses an internal 3-bit bit counter that generates a byte-boundary strobe in place of divided clocks, so the whole block stays on one clock domain.

---
 rtl/paralelo_serial_pkg.sv | 14 +
 rtl/serial_paralelo_rx_if.sv | 22 ++
 rtl/serial_paralelo_rx_comma_detect.sv | 12 +
 rtl/serial_paralelo_rx.sv | 97 +++++++++
 tb/tb_serial_paralelo_rx.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/paralelo_serial_pkg.sv
// Shared definitions for the ParaleloSerial lane (transmitter and receiver sides).
// Holds the lane state encoding, the comma symbol and the byte width.
package paralelo_serial_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } lane_state_e;

    localparam logic [7:0] COMMA_BC = 8'hBC;
    localparam int         BYTE_W   = 8;

endpackage

// File: rtl/serial_paralelo_rx_if.sv
// Serial input / parallel output bundle of the lane receiver.
// The master side drives the bit stream; the slave side is the receiver.
interface serial_paralelo_rx_if;
    import paralelo_serial_pkg::*;

    logic              enb;
    logic              data_in;
    logic [BYTE_W-1:0] data_out;
    logic              valid_out;
    logic              byte_strobe;
    logic              active;

    modport master (
        output enb, data_in,
        input  data_out, valid_out, byte_strobe, active
    );

    modport slave (
        input  enb, data_in,
        output data_out, valid_out, byte_strobe, active
    );
endinterface

// File: rtl/serial_paralelo_rx_comma_detect.sv
// Combinational comparison of a candidate byte against the comma symbol.
// Also used by the transmitter-side idle insertion checker.
module comma_detect
    import paralelo_serial_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COMMA = COMMA_BC
) (
    input  logic [BYTE_W-1:0] nb,
    output logic              match
);
    assign match = (nb == COMMA);
endmodule

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel lane receiver: comma search, lock after BC_LOCK aligned commas,
// then byte presentation with one-cycle strobes, all on the single bit clock.
module serial_paralelo_rx
    import paralelo_serial_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COMMA   = COMMA_BC,
    parameter int                BC_LOCK = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_paralelo_rx_if.slave  bus
);
    localparam logic [1:0] ST_SEARCH = 2'(SEARCH);
    localparam logic [1:0] ST_ALIGN  = 2'(ALIGN);
    localparam logic [1:0] ST_ACTIVE = 2'(ACTIVE);
    localparam logic [3:0] BC_LOCK_W = 4'(BC_LOCK);
    localparam logic [1:0] ST_AFTER_MATCH = (BC_LOCK == 1) ? ST_ACTIVE : ST_ALIGN;

    logic [1:0]        state_reg;
    logic [BYTE_W-1:0] shift_reg;
    logic [2:0]        bit_cnt_reg;
    logic [3:0]        bc_cnt_reg;
    logic [BYTE_W-1:0] data_out_reg;
    logic              valid_reg;
    logic              strobe_reg;

    logic [BYTE_W-1:0] nb;
    logic              is_comma;
    logic              byte_done;
    logic [3:0]        bc_cnt_next;

    assign nb          = {shift_reg[BYTE_W-2:0], bus.data_in};
    assign byte_done   = (bit_cnt_reg == 3'd7);
    assign bc_cnt_next = bc_cnt_reg + 4'd1;

    comma_detect #(.COMMA(COMMA)) u_comma_detect (
        .nb    (nb),
        .match (is_comma)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_SEARCH;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            bc_cnt_reg   <= '0;
            data_out_reg <= '0;
            valid_reg    <= 1'b0;
            strobe_reg   <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses; they only rise on an enabled byte boundary.
            valid_reg  <= 1'b0;
            strobe_reg <= 1'b0;
            if (bus.enb) begin
                shift_reg <= nb;
                case (state_reg)
                    ST_SEARCH: begin
                        if (is_comma) begin
                            bit_cnt_reg <= '0;
                            bc_cnt_reg  <= 4'd1;
                            state_reg   <= ST_AFTER_MATCH;
                        end
                    end
                    ST_ALIGN: begin
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (byte_done) begin
                            if (is_comma) begin
                                bc_cnt_reg <= bc_cnt_next;
                                // The locking comma itself is swallowed, not presented.
                                if (bc_cnt_next == BC_LOCK_W)
                                    state_reg <= ST_ACTIVE;
                            end else begin
                                bc_cnt_reg <= '0;
                                state_reg  <= ST_SEARCH;
                            end
                        end
                    end
                    ST_ACTIVE: begin
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (byte_done) begin
                            data_out_reg <= nb;
                            strobe_reg   <= 1'b1;
                            valid_reg    <= ~is_comma;
                        end
                    end
                    default: state_reg <= ST_SEARCH;
                endcase
            end
        end
    end

    assign bus.data_out    = data_out_reg;
    assign bus.valid_out   = valid_reg;
    assign bus.byte_strobe = strobe_reg;
    assign bus.active      = (state_reg == ST_ACTIVE);

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: table vectors, directed corner sequences and random
// streams checked every cycle against a bit-history reference model.
module tb_serial_paralelo_rx;
    localparam logic [7:0] BC   = 8'hBC;
    localparam int         LOCK = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_paralelo_rx_if bus();

    serial_paralelo_rx #(.COMMA(BC), .BC_LOCK(LOCK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: enabled-bit count, 8-bit window, anchor bit index and comma run.
    int         m_n;
    int         m_win;
    int         m_anchor;
    int         m_run;
    bit         m_locked;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_strobe;

    typedef struct {
        logic [7:0] payload;
        int         ncommas;
        logic       exp_active;
        logic       exp_strobe;
        logic       exp_valid;
        logic [7:0] exp_data;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_n = 0; m_win = 0; m_anchor = 0; m_run = 0; m_locked = 0;
        m_data = 8'h00; m_valid = 0; m_strobe = 0;
    endtask

    task automatic model_bit(input logic b, input logic e);
        logic [7:0] nb;
        m_valid = 0;
        m_strobe = 0;
        if (!e) return;
        m_n++;
        m_win = (m_win * 2 + int'(b)) % 256;
        nb = 8'(m_win);
        if (m_locked) begin
            if ((m_n - m_anchor) % 8 == 0) begin
                m_data = nb; m_strobe = 1; m_valid = (nb != BC);
            end
        end else if (m_run == 0) begin
            if (nb == BC) begin
                m_anchor = m_n; m_run = 1;
                if (LOCK == 1) m_locked = 1;
            end
        end else if ((m_n - m_anchor) % 8 == 0) begin
            if (nb == BC) begin
                m_run++;
                if (m_run == LOCK) m_locked = 1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic step(input logic b, input logic e);
        bus.data_in = b;
        bus.enb = e;
        @(posedge clk);
        model_bit(b, e);
        #1;
        chk("model_data", 32'(bus.data_out), 32'(m_data));
        chk("model_valid", 32'(bus.valid_out), 32'(m_valid));
        chk("model_strobe", 32'(bus.byte_strobe), 32'(m_strobe));
        chk("model_active", 32'(bus.active), 32'(m_locked));
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) step(v[i], 1'b1);
    endtask

    task automatic do_reset();
        bus.enb = 0;
        bus.data_in = 0;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_clear();
    endtask

    int n_strobe;
    int n_valid;

    initial begin
        tbl[0] = '{8'h5A, 4, 1'b1, 1'b1, 1'b1, 8'h5A};
        tbl[1] = '{8'hC3, 4, 1'b1, 1'b1, 1'b1, 8'hC3};
        tbl[2] = '{8'h11, 3, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[3] = '{8'hBC, 4, 1'b1, 1'b1, 1'b0, 8'hBC};
        tbl[4] = '{8'h00, 5, 1'b1, 1'b1, 1'b1, 8'h00};
        tbl[5] = '{8'hBC, 3, 1'b1, 1'b0, 1'b0, 8'h00};

        model_clear();
        bus.enb = 0;
        bus.data_in = 0;
        #12;
        chk("reset_data", 32'(bus.data_out), 32'h00);
        chk("reset_valid", 32'(bus.valid_out), 32'h0);
        chk("reset_strobe", 32'(bus.byte_strobe), 32'h0);
        chk("reset_active", 32'(bus.active), 32'h0);
        do_reset();

        for (int t = 0; t < 6; t++) begin
            do_reset();
            for (int c = 0; c < tbl[t].ncommas; c++) send_byte(BC);
            send_byte(tbl[t].payload);
            $display("vector %0d payload=%h commas=%0d data_out=%h valid=%b strobe=%b active=%b",
                     t, tbl[t].payload, tbl[t].ncommas, bus.data_out, bus.valid_out,
                     bus.byte_strobe, bus.active);
            chk("tbl_active", 32'(bus.active), 32'(tbl[t].exp_active));
            chk("tbl_strobe", 32'(bus.byte_strobe), 32'(tbl[t].exp_strobe));
            chk("tbl_valid", 32'(bus.valid_out), 32'(tbl[t].exp_valid));
            chk("tbl_data", 32'(bus.data_out), 32'(tbl[t].exp_data));
        end

        // Basic lock: active exactly at bit 32, byte presented at bit 40 for one cycle.
        do_reset();
        send_byte(BC); send_byte(BC); send_byte(BC);
        for (int i = 7; i >= 1; i--) step(BC[i], 1'b1);
        chk("lock_bit31_inactive", 32'(bus.active), 32'h0);
        step(BC[0], 1'b1);
        chk("lock_bit32_active", 32'(bus.active), 32'h1);
        send_byte(8'h5A);
        chk("basic_data", 32'(bus.data_out), 32'h5A);
        chk("basic_valid", 32'(bus.valid_out), 32'h1);
        step(1'b0, 1'b1);
        chk("basic_valid_one_cycle", 32'(bus.valid_out), 32'h0);
        chk("basic_strobe_one_cycle", 32'(bus.byte_strobe), 32'h0);
        $display("basic lock data_out=%h active=%b", bus.data_out, bus.active);

        // Unaligned start.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'($urandom_range(1)), 1'b1);
        for (int c = 0; c < 4; c++) send_byte(BC);
        send_byte(8'hC3);
        chk("unaligned_data", 32'(bus.data_out), 32'hC3);
        chk("unaligned_valid", 32'(bus.valid_out), 32'h1);
        $display("unaligned data_out=%h valid=%b", bus.data_out, bus.valid_out);

        // Broken comma run: restart count at the trailing comma.
        do_reset();
        send_byte(BC); send_byte(BC); send_byte(8'h00);
        chk("broken_inactive_a", 32'(bus.active), 32'h0);
        send_byte(BC); send_byte(BC); send_byte(BC);
        chk("broken_inactive_b", 32'(bus.active), 32'h0);
        send_byte(BC);
        chk("broken_relock", 32'(bus.active), 32'h1);
        $display("broken run relock active=%b", bus.active);

        // Enb gap in the middle of 0xA7 (continues from the lock above).
        for (int i = 7; i >= 4; i--) step(8'hA7 >> i, 1'b1);
        for (int g = 0; g < 3; g++) begin
            step(1'b1, 1'b0);
            chk("gap_no_strobe", 32'(bus.byte_strobe), 32'h0);
        end
        for (int i = 3; i >= 1; i--) step(8'hA7 >> i, 1'b1);
        chk("gap_not_early", 32'(bus.byte_strobe), 32'h0);
        step(8'hA7 & 8'h01, 1'b1);
        chk("gap_data", 32'(bus.data_out), 32'hA7);
        chk("gap_valid", 32'(bus.valid_out), 32'h1);
        $display("enb gap data_out=%h valid=%b", bus.data_out, bus.valid_out);

        // Idle filtering: three strobes, one valid.
        n_strobe = 0;
        n_valid = 0;
        for (int b = 0; b < 3; b++) begin
            logic [7:0] v;
            v = (b == 1) ? 8'h11 : BC;
            for (int i = 7; i >= 0; i--) begin
                step(v[i], 1'b1);
                n_strobe += int'(bus.byte_strobe);
                n_valid += int'(bus.valid_out);
            end
        end
        chk("idle_strobes", 32'(n_strobe), 32'd3);
        chk("idle_valids", 32'(n_valid), 32'd1);
        $display("idle filtering strobes=%0d valids=%0d", n_strobe, n_valid);

        // Asynchronous reset mid-byte while active.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        chk("pre_areset_data", 32'(bus.data_out), 32'(BC));
        @(posedge clk);
        #3;
        rst = 1;
        #1;
        chk("areset_active", 32'(bus.active), 32'h0);
        chk("areset_data", 32'(bus.data_out), 32'h00);
        chk("areset_strobe", 32'(bus.byte_strobe), 32'h0);
        @(posedge clk);
        #1;
        rst = 0;
        model_clear();
        send_byte(BC); send_byte(BC); send_byte(BC);
        chk("areset_relock_pending", 32'(bus.active), 32'h0);
        send_byte(BC);
        chk("areset_relock", 32'(bus.active), 32'h1);
        $display("async reset relock active=%b", bus.active);

        // Random streams checked every cycle against the model.
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int i = 0; i < int'($urandom_range(7)); i++) step(1'($urandom_range(1)), 1'b1);
            for (int k = 0; k < 40; k++) begin
                logic [7:0] v;
                v = ($urandom_range(99) < 55) ? BC : 8'($urandom);
                for (int i = 7; i >= 0; i--) begin
                    while ($urandom_range(99) < 15) step(1'($urandom_range(1)), 1'b0);
                    step(v[i], 1'b1);
                end
            end
            $display("random run %0d active=%b last data_out=%h errors=%0d",
                     r, bus.active, bus.data_out, errors);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
